// File: rtl/pushbutton_debouncer.sv
// pushbutton_debouncer
//   Conditions raw board pushbutton pins for the Nios pushbutton PIO.
//   Each button is synchronized to clk through a 2-FF chain, then filtered
//   by a per-bit stability counter: a new synchronized value is accepted
//   only after it has persisted for DEBOUNCE_CYCLES consecutive cycles.
//   The accepted level keeps pin polarity; single-cycle press/release
//   strobes accompany each accepted transition.
//
// Parameters
//   WIDTH           number of buttons (PIO in_port width)
//   DEBOUNCE_CYCLES cycles a new value must persist before acceptance (>= 1)
//   ACTIVE_LOW      1: pin reads 0 when pressed; 0: pin reads 1 when pressed
//
// Ports
//   clk           in   1      system clock (PIO clock)
//   reset         in   1      asynchronous, active-high reset
//   btn_raw       in   WIDTH  raw asynchronous button pins
//   btn_level     out  WIDTH  debounced level, pin polarity (to PIO in_port)
//   press_pulse   out  WIDTH  1-cycle strobe on accepted idle->pressed
//   release_pulse out  WIDTH  1-cycle strobe on accepted pressed->idle
module pushbutton_debouncer #(
  parameter int unsigned WIDTH           = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned ACTIVE_LOW      = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] btn_raw,
  output logic [WIDTH-1:0] btn_level,
  output logic [WIDTH-1:0] press_pulse,
  output logic [WIDTH-1:0] release_pulse
);

  localparam int unsigned      CW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [WIDTH-1:0] IDLE = {WIDTH{(ACTIVE_LOW != 0)}};
  localparam logic [CW-1:0]    LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0]    ONE  = CW'(1);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_level;
  logic [WIDTH-1:0] r_press;
  logic [WIDTH-1:0] r_release;
  logic [CW-1:0]    r_cnt [WIDTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1   <= IDLE;
      r_sync2   <= IDLE;
      r_level   <= IDLE;
      r_press   <= '0;
      r_release <= '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        r_press[i]   <= 1'b0;
        r_release[i] <= 1'b0;
        if (r_sync2[i] == r_level[i]) begin
          // Any agreeing cycle restarts the stability window.
          r_cnt[i] <= '0;
        end else if (r_cnt[i] < LAST) begin
          r_cnt[i] <= r_cnt[i] + ONE;
        end else begin
          // Value has differed for DEBOUNCE_CYCLES cycles: accept it.
          r_level[i] <= r_sync2[i];
          r_cnt[i]   <= '0;
          if (r_sync2[i] != IDLE[i]) begin
            r_press[i] <= 1'b1;
          end else begin
            r_release[i] <= 1'b1;
          end
        end
      end
    end
  end

  assign btn_level     = r_level;
  assign press_pulse   = r_press;
  assign release_pulse = r_release;

endmodule

// File: tb/tb_pushbutton_debouncer.sv
module tb_pushbutton_debouncer;

  logic       clk;
  logic       reset;
  logic [1:0] btn_raw;
  logic [1:0] btn_level;
  logic [1:0] press_pulse;
  logic [1:0] release_pulse;

  int n_checks;
  int n_errors;

  pushbutton_debouncer #(
    .WIDTH          (2),
    .DEBOUNCE_CYCLES(4),
    .ACTIVE_LOW     (1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_raw      (btn_raw),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one rising edge; sample point is 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    btn_raw = 2'b00;
    reset   = 1'b1;
    #2;
    n_checks++;
    if (btn_level !== 2'b11 || press_pulse !== 2'b00 || release_pulse !== 2'b00) begin
      n_errors++;
      $display("FAIL reset_async: level=%b press=%b rel=%b want 11/00/00", btn_level, press_pulse, release_pulse);
    end
    step();
    step();
    n_checks++;
    if (btn_level !== 2'b11 || press_pulse !== 2'b00 || release_pulse !== 2'b00) begin
      n_errors++;
      $display("FAIL reset_held: level=%b press=%b rel=%b want 11/00/00", btn_level, press_pulse, release_pulse);
    end
    reset = 1'b0;
    step();
    n_checks++;
    if (btn_level !== 2'b11 || press_pulse !== 2'b00 || release_pulse !== 2'b00) begin
      n_errors++;
      $display("FAIL reset_after: level=%b press=%b rel=%b want 11/00/00", btn_level, press_pulse, release_pulse);
    end
    // Return pins to idle; the brief low on sync2 is far shorter than the window.
    btn_raw = 2'b11;
    for (int e = 1; e <= 8; e++) begin
      step();
      n_checks++;
      if (btn_level !== 2'b11 || press_pulse !== 2'b00 || release_pulse !== 2'b00) begin
        n_errors++;
        $display("FAIL reset_settle e=%0d: level=%b press=%b rel=%b want 11/00/00", e, btn_level, press_pulse, release_pulse);
      end
    end
  endtask

  task automatic test_press_release();
    logic [1:0] el, ep, er;
    btn_raw = 2'b10;
    for (int e = 1; e <= 7; e++) begin
      step();
      el = (e >= 6) ? 2'b10 : 2'b11;
      ep = (e == 6) ? 2'b01 : 2'b00;
      er = 2'b00;
      n_checks++;
      if (btn_level !== el || press_pulse !== ep || release_pulse !== er) begin
        n_errors++;
        $display("FAIL press e=%0d: level=%b/%b press=%b/%b rel=%b/%b (got/want)", e, btn_level, el, press_pulse, ep, release_pulse, er);
      end
    end
    btn_raw = 2'b11;
    for (int e = 1; e <= 7; e++) begin
      step();
      el = (e >= 6) ? 2'b11 : 2'b10;
      ep = 2'b00;
      er = (e == 6) ? 2'b01 : 2'b00;
      n_checks++;
      if (btn_level !== el || press_pulse !== ep || release_pulse !== er) begin
        n_errors++;
        $display("FAIL release e=%0d: level=%b/%b press=%b/%b rel=%b/%b (got/want)", e, btn_level, el, press_pulse, ep, release_pulse, er);
      end
    end
  endtask

  task automatic test_glitch();
    for (int e = 1; e <= 10; e++) begin
      btn_raw = (e <= 3) ? 2'b01 : 2'b11;
      step();
      n_checks++;
      if (btn_level !== 2'b11 || press_pulse !== 2'b00 || release_pulse !== 2'b00) begin
        n_errors++;
        $display("FAIL glitch e=%0d: level=%b press=%b rel=%b want 11/00/00", e, btn_level, press_pulse, release_pulse);
      end
    end
  endtask

  task automatic test_bounce();
    logic [1:0] el, ep;
    // Low before edges 1,3,5; high before 2,4; held low from edge 5 on.
    for (int e = 1; e <= 12; e++) begin
      if (e == 1 || e == 3 || e >= 5) btn_raw = 2'b10;
      else btn_raw = 2'b11;
      step();
      el = (e >= 10) ? 2'b10 : 2'b11;
      ep = (e == 10) ? 2'b01 : 2'b00;
      n_checks++;
      if (btn_level !== el || press_pulse !== ep || release_pulse !== 2'b00) begin
        n_errors++;
        $display("FAIL bounce e=%0d: level=%b/%b press=%b/%b rel=%b/00 (got/want)", e, btn_level, el, press_pulse, ep, release_pulse);
      end
    end
    btn_raw = 2'b11;
    for (int e = 1; e <= 7; e++) step();
    n_checks++;
    if (btn_level !== 2'b11) begin
      n_errors++;
      $display("FAIL bounce_cleanup: level=%b want 11", btn_level);
    end
  endtask

  task automatic test_simultaneous();
    logic [1:0] raw_seq [4];
    logic [1:0] lvl_seq [4];
    logic [1:0] prs_seq [4];
    logic [1:0] rel_seq [4];
    logic [1:0] prev, el, ep, er;
    raw_seq = '{2'b00, 2'b01, 2'b10, 2'b11};
    lvl_seq = '{2'b00, 2'b01, 2'b10, 2'b11};
    prs_seq = '{2'b11, 2'b00, 2'b01, 2'b00};
    rel_seq = '{2'b00, 2'b01, 2'b10, 2'b01};
    prev = 2'b11;
    for (int s = 0; s < 4; s++) begin
      btn_raw = raw_seq[s];
      for (int e = 1; e <= 7; e++) begin
        step();
        el = (e >= 6) ? lvl_seq[s] : prev;
        ep = (e == 6) ? prs_seq[s] : 2'b00;
        er = (e == 6) ? rel_seq[s] : 2'b00;
        n_checks++;
        if (btn_level !== el || press_pulse !== ep || release_pulse !== er) begin
          n_errors++;
          $display("FAIL simul s=%0d e=%0d: level=%b/%b press=%b/%b rel=%b/%b (got/want)", s, e, btn_level, el, press_pulse, ep, release_pulse, er);
        end
      end
      prev = lvl_seq[s];
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] el, ep;
    btn_raw = 2'b10;
    for (int e = 1; e <= 5; e++) step();  // counts at edges 3,4,5
    reset = 1'b1;
    #1;
    n_checks++;
    if (btn_level !== 2'b11 || press_pulse !== 2'b00 || release_pulse !== 2'b00) begin
      n_errors++;
      $display("FAIL rstmid_assert: level=%b press=%b rel=%b want 11/00/00", btn_level, press_pulse, release_pulse);
    end
    step();
    step();
    n_checks++;
    if (btn_level !== 2'b11 || press_pulse !== 2'b00) begin
      n_errors++;
      $display("FAIL rstmid_held: level=%b press=%b want 11/00", btn_level, press_pulse);
    end
    reset = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      step();
      el = (e >= 6) ? 2'b10 : 2'b11;
      ep = (e == 6) ? 2'b01 : 2'b00;
      n_checks++;
      if (btn_level !== el || press_pulse !== ep || release_pulse !== 2'b00) begin
        n_errors++;
        $display("FAIL rstmid_reaccept e=%0d: level=%b/%b press=%b/%b rel=%b/00 (got/want)", e, btn_level, el, press_pulse, ep, release_pulse);
      end
    end
    // Reset of an already accepted press must clear the level without a clock edge.
    reset = 1'b1;
    #1;
    n_checks++;
    if (btn_level !== 2'b11 || press_pulse !== 2'b00 || release_pulse !== 2'b00) begin
      n_errors++;
      $display("FAIL rstmid_accepted: level=%b press=%b rel=%b want 11/00/00", btn_level, press_pulse, release_pulse);
    end
    btn_raw = 2'b11;
    step();
    reset = 1'b0;
    step();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b0;
    btn_raw  = 2'b11;
    #3;
    test_reset();
    test_press_release();
    test_glitch();
    test_bounce();
    test_simultaneous();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
